// File: rtl/wb_sevenseg.sv
// Wishbone slave driving an 8-digit multiplexed seven-segment display.
// Hex or raw segment patterns, programmable frame rate and per-slot anode blanking.
module wb_sevenseg #(
    parameter int ARCHBITSZ = 32,
    parameter int CLKFREQ   = 100000000,
    parameter int REFRESHHZ = 1000,
    parameter int BLANKCYC  = 16
) (
    input  logic                                         rst_i,
    input  logic                                         clk_i,
    input  logic                                         wb_cyc_i,
    input  logic                                         wb_stb_i,
    input  logic                                         wb_we_i,
    input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]     wb_addr_i,
    input  logic [ARCHBITSZ/8-1:0]                       wb_sel_i,
    input  logic [ARCHBITSZ-1:0]                         wb_dat_i,
    output logic                                         wb_bsy_o,
    output logic                                         wb_ack_o,
    output logic [ARCHBITSZ-1:0]                         wb_dat_o,
    output logic [ARCHBITSZ-1:0]                         wb_mapsz_o,
    output logic [7:0]                                   an_o,
    output logic [7:0]                                   seg_o
);

    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8);
    localparam int DWELL     = CLKFREQ / (REFRESHHZ * 8);
    localparam int CNTW      = (DWELL > 2) ? $clog2(DWELL) : 1;

    logic [31:0]     value;
    logic [7:0]      en_mask;
    logic [7:0]      dp_mask;
    logic            raw_mode;
    logic [63:0]     raw;
    logic [CNTW-1:0] dwell;
    logic [2:0]      d;
    logic            acc;
    logic [31:0]     rdata;
    logic [3:0]      nib;
    logic [7:0]      pat;
    logic            unused;

    assign acc        = wb_cyc_i & wb_stb_i;
    assign wb_bsy_o   = 1'b0;
    assign wb_mapsz_o = ARCHBITSZ'(16);
    assign unused     = ^wb_addr_i[ADDRBITSZ-1:2];

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // Register file; each byte lane honours its select independently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value    <= '0;
            en_mask  <= '0;
            dp_mask  <= '0;
            raw_mode <= 1'b0;
            raw      <= '0;
        end else if (acc && wb_we_i) begin
            case (wb_addr_i[1:0])
                2'd0: for (int b = 0; b < 4; b++)
                          if (wb_sel_i[b]) value[8*b +: 8] <= wb_dat_i[8*b +: 8];
                2'd1: begin
                    if (wb_sel_i[0]) en_mask  <= wb_dat_i[7:0];
                    if (wb_sel_i[1]) dp_mask  <= wb_dat_i[15:8];
                    if (wb_sel_i[2]) raw_mode <= wb_dat_i[16];
                end
                2'd2: for (int b = 0; b < 4; b++)
                          if (wb_sel_i[b]) raw[8*b +: 8] <= wb_dat_i[8*b +: 8];
                default: for (int b = 0; b < 4; b++)
                          if (wb_sel_i[b]) raw[32 + 8*b +: 8] <= wb_dat_i[8*b +: 8];
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (wb_addr_i[1:0])
            2'd0:    rdata = value;
            2'd1:    rdata = {15'b0, raw_mode, dp_mask, en_mask};
            2'd2:    rdata = raw[31:0];
            default: rdata = raw[63:32];
        endcase
    end

    // Read data is forced to zero outside an ack so the interconnect can OR slaves.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= acc;
            wb_dat_o <= acc ? ARCHBITSZ'(rdata) : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dwell <= '0;
            d     <= '0;
        end else if (dwell == CNTW'(DWELL-1)) begin
            dwell <= '0;
            d     <= d + 3'd1;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    always_comb begin
        nib = value[{d, 2'b00} +: 4];
        pat = raw_mode ? raw[{d, 3'b000} +: 8] : {dp_mask[d], hex7(nib)};
    end

    // Leading blank cycles of every slot keep the previous digit from ghosting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            an_o  <= 8'hFF;
            seg_o <= 8'hFF;
        end else if (dwell < CNTW'(BLANKCYC) || !en_mask[d]) begin
            an_o  <= 8'hFF;
            seg_o <= 8'hFF;
        end else begin
            an_o  <= ~(8'b1 << d);
            seg_o <= ~pat;
        end
    end

endmodule

// File: tb/tb_wb_sevenseg.sv
// Directed bench for wb_sevenseg: register table, async reset, scan timing, raw/dp and bus streaming.
module tb_wb_sevenseg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [29:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdat = '0;
    logic        bsy, ack;
    logic [31:0] rdat, mapsz;
    logic [7:0]  an, seg;

    int nvec = 0;
    int nerr = 0;

    wb_sevenseg #(.ARCHBITSZ(32), .CLKFREQ(800), .REFRESHHZ(10), .BLANKCYC(2)) dut (
        .rst_i(rst), .clk_i(clk), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_addr_i(addr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_bsy_o(bsy),
        .wb_ack_o(ack), .wb_dat_o(rdat), .wb_mapsz_o(mapsz), .an_o(an), .seg_o(seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          wr;
        logic [29:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wb_write(input logic [29:0] a, input logic [3:0] s, input logic [31:0] d);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; addr = a; sel = s; wdat = d;
        @(negedge clk);
        chk("write_ack", {31'b0, ack}, 32'd1);
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wb_read(input string nm, input logic [29:0] a, input logic [31:0] exp);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; addr = a; sel = 4'hF;
        @(negedge clk);
        chk({nm, "_ack"}, {31'b0, ack}, 32'd1);
        chk(nm, rdat, exp);
        cyc = 0; stb = 0;
    endtask

    task automatic wait_an(input logic [7:0] v);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (an === v) ok = 1;
        end
        if (!ok) chk("wait_an_timeout", {24'b0, an}, {24'b0, v});
    endtask

    task automatic sync_digit0();
        wait_an(8'hFF);
        wait_an(8'hFE);
    endtask

    initial begin
        vecs[0]  = '{"rst_value", 0, 30'd0, 4'h0, 32'h0,        32'h0};
        vecs[1]  = '{"rst_ctrl",  0, 30'd1, 4'h0, 32'h0,        32'h0};
        vecs[2]  = '{"ctrl_wr1",  1, 30'd1, 4'h1, 32'hFFFFFFFF, 32'h0};
        vecs[3]  = '{"ctrl_rd1",  0, 30'd1, 4'h0, 32'h0,        32'h000000FF};
        vecs[4]  = '{"ctrl_wr2",  1, 30'd1, 4'h6, 32'h00018000, 32'h0};
        vecs[5]  = '{"ctrl_rd2",  0, 30'd1, 4'h0, 32'h0,        32'h000180FF};
        vecs[6]  = '{"value_wr",  1, 30'd0, 4'hF, 32'h76543210, 32'h0};
        vecs[7]  = '{"value_rd",  0, 30'd0, 4'h0, 32'h0,        32'h76543210};
        vecs[8]  = '{"raw0_wr",   1, 30'd2, 4'hA, 32'hAABBCCDD, 32'h0};
        vecs[9]  = '{"raw0_rd",   0, 30'd2, 4'h0, 32'h0,        32'hAA00CC00};
        vecs[10] = '{"raw1_wr",   1, 30'd3, 4'hF, 32'h12345678, 32'h0};
        vecs[11] = '{"raw1_rd",   0, 30'd3, 4'h0, 32'h0,        32'h12345678};
        vecs[12] = '{"alias_wr",  1, 30'd5, 4'hF, 32'h00000000, 32'h0};
        vecs[13] = '{"alias_rd",  0, 30'd1, 4'h0, 32'h0,        32'h0};
        vecs[14] = '{"hi_addr",   0, 30'h3FFFFFF0, 4'h0, 32'h0, 32'h76543210};

        repeat (3) @(negedge clk);
        chk("rst_an", {24'b0, an}, 32'hFF);
        chk("rst_seg", {24'b0, seg}, 32'hFF);
        rst = 0;

        foreach (vecs[i]) begin
            if (vecs[i].wr) wb_write(vecs[i].a, vecs[i].s, vecs[i].d);
            else            wb_read(vecs[i].name, vecs[i].a, vecs[i].exp);
        end

        // Async reset while a digit is lit and an ack is in flight.
        wb_write(30'd1, 4'hF, 32'h000000FF);
        sync_digit0();
        cyc = 1; stb = 1; we = 0; addr = 30'd0;
        @(posedge clk); #2;
        chk("pre_rst_ack", {31'b0, ack}, 32'd1);
        rst = 1; #1;
        chk("async_an", {24'b0, an}, 32'hFF);
        chk("async_seg", {24'b0, seg}, 32'hFF);
        chk("async_ack", {31'b0, ack}, 32'd0);
        chk("async_dat", rdat, 32'd0);
        @(negedge clk); cyc = 0; stb = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        wb_read("post_value", 30'd0, 32'h0);
        wb_read("post_ctrl",  30'd1, 32'h0);
        wb_read("post_raw0",  30'd2, 32'h0);
        wb_read("post_raw1",  30'd3, 32'h0);

        // Hex scan timing.
        wb_write(30'd0, 4'hF, 32'h76543210);
        wb_write(30'd1, 4'hF, 32'h000000FF);
        sync_digit0();
        for (int i = 0; i < 8; i++) begin
            chk("d0_an", {24'b0, an}, 32'hFE); chk("d0_seg", {24'b0, seg}, 32'hC0);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            chk("blank_an", {24'b0, an}, 32'hFF); chk("blank_seg", {24'b0, seg}, 32'hFF);
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            chk("d1_an", {24'b0, an}, 32'hFD); chk("d1_seg", {24'b0, seg}, 32'hF9);
            @(negedge clk);
        end
        repeat (52) @(negedge clk);
        chk("d7_an", {24'b0, an}, 32'h7F); chk("d7_seg", {24'b0, seg}, 32'hF8);
        repeat (10) @(negedge clk);
        chk("wrap_an", {24'b0, an}, 32'hFE); chk("wrap_seg", {24'b0, seg}, 32'hC0);

        // Raw mode and decimal point.
        wb_write(30'd1, 4'hF, 32'h000101FF);
        wb_write(30'd2, 4'hF, 32'h000000AA);
        sync_digit0();
        chk("raw_d0_seg", {24'b0, seg}, 32'h55);
        repeat (10) @(negedge clk);
        chk("raw_d1_an", {24'b0, an}, 32'hFD);
        chk("raw_d1_seg", {24'b0, seg}, 32'hFF);
        wb_write(30'd1, 4'hF, 32'h000001FF);
        wb_write(30'd0, 4'hF, 32'h00000000);
        sync_digit0();
        chk("dp_d0_seg", {24'b0, seg}, 32'h40);

        // Streamed reads with strobe held.
        wb_write(30'd1, 4'hF, 32'h00000005);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; addr = 30'd0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e[4];
            e = '{32'h0, 32'h00000005, 32'h000000AA, 32'h0};
            @(negedge clk);
            chk("stream_ack", {31'b0, ack}, 32'd1);
            chk("stream_dat", rdat, e[i]);
            chk("stream_bsy", {31'b0, bsy}, 32'd0);
            addr = 30'(i + 1);
        end
        cyc = 0; stb = 0;
        @(negedge clk);
        chk("idle_ack", {31'b0, ack}, 32'd0);
        chk("idle_dat", rdat, 32'd0);
        chk("mapsz", mapsz, 32'd16);

        // Enable mask 0x05: only digits 0 and 2 may light.
        begin
            int bad = 0;
            bit saw0 = 0, saw2 = 0;
            repeat (3) @(negedge clk);
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (an == 8'hFE) saw0 = 1;
                else if (an == 8'hFB) saw2 = 1;
                else if (an != 8'hFF) bad++;
            end
            chk("mask_bad_anodes", bad, 0);
            chk("mask_saw_d0", {31'b0, saw0}, 32'd1);
            chk("mask_saw_d2", {31'b0, saw2}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
